// File: rtl/fpu_pkg.sv
// Shared FPU types: operand width, multiplier tag and default multiplier latency.
package fpu_pkg;

  localparam int FP_W     = 32;
  localparam int FMUL_LAT = 2;
  // Wide enough for the largest supported requester count (8).
  localparam int TAG_IDW  = 3;

  typedef struct packed {
    logic               vld;
    logic [TAG_IDW-1:0] id;
  } fmul_tag_t;

endpackage

// File: rtl/fmul_issue_arb_if.sv
// Request, multiplier and response signals of fmul_issue_arb, with modports for
// the arbiter (slave) and its environment (master).
// Handshake: an operand pair moves when req_valid[i] & req_ready[i] are high at a rising edge;
// responses have no back-pressure and are valid for exactly one cycle.
interface fmul_issue_arb_if #(
  parameter int NREQ = 2
) ();
  import fpu_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*FP_W-1:0] req_x1;
  logic [NREQ*FP_W-1:0] req_x2;
  logic                 hold;
  logic [FP_W-1:0]      mul_x1;
  logic [FP_W-1:0]      mul_x2;
  logic [FP_W-1:0]      mul_y;
  logic                 mul_ovf;
  logic [NREQ-1:0]      resp_valid;
  logic [FP_W-1:0]      resp_y;
  logic                 resp_ovf;
  logic                 busy;
  logic [NREQ-1:0]      ovf_sticky;
  logic [NREQ-1:0]      ovf_clr;

  modport slave (
    input  req_valid, req_x1, req_x2, hold, mul_y, mul_ovf, ovf_clr,
    output req_ready, mul_x1, mul_x2, resp_valid, resp_y, resp_ovf, busy, ovf_sticky
  );

  modport master (
    output req_valid, req_x1, req_x2, hold, mul_y, mul_ovf, ovf_clr,
    input  req_ready, mul_x1, mul_x2, resp_valid, resp_y, resp_ovf, busy, ovf_sticky
  );

endinterface

// File: rtl/fmul_issue_arb_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o
);

  logic found;
  int   idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (en_i && !found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fmul_issue_arb.sv
// Round-robin issue arbiter for a shared, fully pipelined multiplier with tag return path.
// Optional sticky per-requester overflow flags: define FMUL_ARB_STICKY_OVF_EN.
module fmul_issue_arb
  import fpu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = FMUL_LAT
) (
  input  logic            clk,
  input  logic            rstn,
  fmul_issue_arb_if.slave bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            arb_en;
  logic            transfer;
  logic [FP_W-1:0] mul_x1_c, mul_x2_c;

  fmul_tag_t       tag_q [LAT];
  fmul_tag_t       tag_d;
  fmul_tag_t       last_tag;
  logic            pipe_busy;

  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [FP_W-1:0] resp_y_q;
  logic            resp_ovf_q;

  // Reset gates the grant so nothing is accepted while the pipe is being cleared.
  assign arb_en = rstn & ~bus.hold;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i       (bus.req_valid),
    .en_i        (arb_en),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign transfer = |grant;

  always_comb begin
    mul_x1_c = '0;
    mul_x2_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        mul_x1_c = bus.req_x1[i*FP_W +: FP_W];
        mul_x2_c = bus.req_x2[i*FP_W +: FP_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) begin
      if (int'(grant_idx) == NREQ - 1) rr_ptr_d = '0;
      else                             rr_ptr_d = grant_idx + IDW'(1);
    end
  end

  always_comb begin
    tag_d.vld = transfer;
    tag_d.id  = TAG_IDW'(grant_idx);
  end

  assign last_tag = tag_q[LAT-1];

  always_comb begin
    resp_valid_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid_d[i] = last_tag.vld && (int'(last_tag.id) == i);
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      pipe_busy = pipe_busy | tag_q[s].vld;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag_q[0] <= tag_d;
      for (int s = 1; s < LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // The multiplier result lines up with the last tag stage; capture only then.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid_q <= '0;
      resp_y_q     <= '0;
      resp_ovf_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      if (last_tag.vld) begin
        resp_y_q   <= bus.mul_y;
        resp_ovf_q <= bus.mul_ovf;
      end
    end
  end

`ifdef FMUL_ARB_STICKY_OVF_EN
  logic [NREQ-1:0] sticky_q;

  // Set has priority over a clear on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sticky_q <= '0;
    else       sticky_q <= (sticky_q & ~bus.ovf_clr) | (resp_valid_q & {NREQ{resp_ovf_q}});
  end

  assign bus.ovf_sticky = sticky_q;
`else
  assign bus.ovf_sticky = '0;
`endif

  assign bus.req_ready  = grant;
  assign bus.mul_x1     = mul_x1_c;
  assign bus.mul_x2     = mul_x2_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_y     = resp_y_q;
  assign bus.resp_ovf   = resp_ovf_q;
  assign bus.busy       = pipe_busy | (|resp_valid_q);

endmodule

// File: tb/tb_fmul_issue_arb.sv
// Directed scoreboard bench for fmul_issue_arb with a 2-cycle multiplier model.
module tb_fmul_issue_arb;

  localparam int NREQ = 2;
  localparam int LAT  = 2;
  localparam int W    = 32 + NREQ + 1 + 32;

`ifdef FMUL_ARB_STICKY_OVF_EN
  localparam logic [NREQ-1:0] STICKY_EXP = 2'b10;
`else
  localparam logic [NREQ-1:0] STICKY_EXP = 2'b00;
`endif

  localparam logic [31:0] ONE = 32'h3F800000;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_cmp;
  int   n_err;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  fmul_issue_arb_if #(.NREQ(NREQ)) bus ();

  fmul_issue_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- multiplier model ----------------
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    if (b == ONE)                                  return {1'b0, a};
    else if (a == 32'h3FC00000 && b == 32'h40000000) return {1'b0, 32'h40400000};
    else if (b == 32'h7F000000)                    return {1'b1, 32'h7F800000};
    else                                           return {1'b0, a ^ b};
  endfunction

  logic [32:0] mp1, mp2;
  always @(posedge clk) begin
    mp1 <= ref_mul(bus.mul_x1, bus.mul_x2);
    mp2 <= mp1;
  end
  assign bus.mul_y   = mp2[31:0];
  assign bus.mul_ovf = mp2[32];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented response must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus.resp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL resp_unexpected: got resp_valid=%b y=%h, required no response (cycle %0d)",
                 bus.resp_valid, bus.resp_y, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_cycle", 64'(cyc), 64'(mon_e[W-1 -: 32]));
        check("resp_id", 64'(bus.resp_valid), 64'(mon_e[33 +: NREQ]));
        check("resp_ovf", 64'(bus.resp_ovf), 64'(mon_e[32]));
        check("resp_y", 64'(bus.resp_y), 64'(mon_e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [NREQ-1:0] v, input logic [63:0] x1, input logic [63:0] x2,
                      input logic h, input logic [NREQ-1:0] exp_rdy, input bit push,
                      input logic [31:0] ey, input logic eovf);
    logic [31:0] ex1, ex2;
    bus.req_valid = v;
    bus.req_x1    = x1;
    bus.req_x2    = x2;
    bus.hold      = h;
    @(negedge clk);
    ex1 = '0;
    ex2 = '0;
    if (exp_rdy[0]) begin ex1 = x1[31:0];  ex2 = x2[31:0];  end
    if (exp_rdy[1]) begin ex1 = x1[63:32]; ex2 = x2[63:32]; end
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check("mul_x1", 64'(bus.mul_x1), 64'(ex1));
    check("mul_x2", 64'(bus.mul_x2), 64'(ex2));
    if (push) exp_q.push_back({32'(cyc + 1 + LAT), exp_rdy, eovf, ey});
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.hold      = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.req_valid = '0;
    bus.hold      = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'(0));
    check({tag, "_resp_y"}, 64'(bus.resp_y), 64'(0));
    check({tag, "_resp_ovf"}, 64'(bus.resp_ovf), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_ovf_sticky"}, 64'(bus.ovf_sticky), 64'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got no end of test, required completion within 200000 time units");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc           = 0;
    n_cmp         = 0;
    n_err         = 0;
    rstn          = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_x1    = '0;
    bus.req_x2    = '0;
    bus.hold      = 1'b0;
    bus.ovf_clr   = '0;

    // Reset values, including no grant while reset is held with requests pending.
    @(negedge clk);
    check_reset_outputs("rst");
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);

    // Single op: 1.5 * 2.0 from requester 0.
    step(2'b01, {32'h0, 32'h3FC00000}, {32'h0, 32'h40000000}, 1'b0, 2'b01, 1'b1, 32'h40400000, 1'b0);
    @(negedge clk);
    check("busy_inflight", 64'(bus.busy), 64'(1));
    @(negedge clk);
    @(negedge clk);
    check("busy_resp", 64'(bus.busy), 64'(1));
    @(negedge clk);
    check("busy_drained", 64'(bus.busy), 64'(0));
    check("resp_y_hold", 64'(bus.resp_y), 64'h40400000);
    @(posedge clk);
    #1;
    idle(2);

    // Contention from a fresh pointer: grants alternate 0,1,0,1.
    do_reset();
    step(2'b11, {32'h200, 32'h100}, {ONE, ONE}, 1'b0, 2'b01, 1'b1, 32'h100, 1'b0);
    step(2'b11, {32'h200, 32'h101}, {ONE, ONE}, 1'b0, 2'b10, 1'b1, 32'h200, 1'b0);
    step(2'b11, {32'h201, 32'h101}, {ONE, ONE}, 1'b0, 2'b01, 1'b1, 32'h101, 1'b0);
    step(2'b11, {32'h201, 32'h102}, {ONE, ONE}, 1'b0, 2'b10, 1'b1, 32'h201, 1'b0);
    idle(5);

    // Back-to-back: requester 1, eight ops, y = x1.
    for (int i = 0; i < 8; i++) begin
      step(2'b10, {32'(i), 32'h0}, {ONE, ONE}, 1'b0, 2'b10, 1'b1, 32'(i), 1'b0);
    end
    idle(5);

    // hold with requests pending; in-flight op still returns; resume at rr_ptr (1).
    step(2'b01, {32'h300, 32'h400}, {ONE, ONE}, 1'b0, 2'b01, 1'b1, 32'h400, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(2'b11, {32'h300, 32'h401}, {ONE, ONE}, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0);
    end
    step(2'b11, {32'h300, 32'h401}, {ONE, ONE}, 1'b0, 2'b10, 1'b1, 32'h300, 1'b0);
    step(2'b11, {32'h301, 32'h401}, {ONE, ONE}, 1'b0, 2'b01, 1'b1, 32'h401, 1'b0);
    idle(5);

    // Reset one cycle after a transfer: that op must never respond.
    step(2'b10, {32'h555, 32'h0}, {ONE, ONE}, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0);
    rstn          = 1'b0;
    bus.req_valid = 2'b11;
    @(negedge clk);
    check_reset_outputs("midrst");
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(6);

    // Overflow response to requester 1 and sticky flag behaviour.
    step(2'b10, {32'h7F000000, 32'h0}, {32'h7F000000, 32'h0}, 1'b0, 2'b10, 1'b1, 32'h7F800000, 1'b1);
    repeat (4) @(negedge clk);
    check("sticky_set", 64'(bus.ovf_sticky), 64'(STICKY_EXP));
    @(posedge clk);
    #1;
    step(2'b10, {32'h7F000000, 32'h0}, {32'h7F000000, 32'h0}, 1'b0, 2'b10, 1'b1, 32'h7F800000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    bus.ovf_clr = 2'b10;
    @(posedge clk);
    #1;
    bus.ovf_clr = 2'b00;
    @(negedge clk);
    check("sticky_set_wins", 64'(bus.ovf_sticky), 64'(STICKY_EXP));
    @(posedge clk);
    #1;
    bus.ovf_clr = 2'b10;
    @(posedge clk);
    #1;
    bus.ovf_clr = 2'b00;
    @(negedge clk);
    check("sticky_clear", 64'(bus.ovf_sticky), 64'(0));
    @(posedge clk);
    #1;

    idle(6);
    check("drain", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fmul_issue_arb.md
# fmul_issue_arb

Round-robin issue arbiter that shares one fully pipelined single-precision multiplier (fixed 2-cycle latency, no stall input, one new operand pair per cycle) between NREQ requesters. It accepts operand pairs over a valid/ready handshake and drives the multiplier's operand ports. A tag pipeline follows each operation through the multiplier and returns each registered result to the requester that issued it. The block sits between the FPU front-end request sources and the multiplier datapath. The multiplier sits outside this block.

## Interface
- NREQ, 2, number of requesters (2..8)
- LAT, 2, multiplier latency: operands presented in cycle c give mul_y valid in cycle c+LAT
- IDW, $clog2(NREQ) (min 1), requester index width (derived)
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, asynchronous assert, active-low; deassertion synchronous to clk
- req_valid  in  NREQ  operand pair valid, one bit per requester
- req_ready  out  NREQ  one-hot or zero grant; combinational from req_valid, hold, rr pointer
- req_x1  in  NREQ*32  operand 1, requester i at [32i+31:32i]
- req_x2  in  NREQ*32  operand 2, same packing
- hold  in  1  when 1, no new issue; in-flight ops drain
- mul_x1  out  32  to multiplier operand 1 (combinational mux of granted requester; 0 when no grant)
- mul_x2  out  32  to multiplier operand 2
- mul_y  in  32  multiplier result
- mul_ovf  in  1  multiplier overflow flag
- resp_valid  out  NREQ  one-hot result strobe, registered
- resp_y  out  32  result, registered
- resp_ovf  out  1  overflow alongside resp_y, registered
- busy  out  1  any operation in flight (registered tag-pipe valid OR)
- ovf_sticky  out  NREQ  sticky overflow per requester (see Configuration)
- ovf_clr  in  NREQ  clear for ovf_sticky

## Operation
- Arbitration: round-robin. Pointer rr_ptr (IDW bits, reset 0). Grant goes to the first i with req_valid[i] when scanning rr_ptr, rr_ptr+1, … modulo NREQ. At most one grant per cycle.
- No grant while hold=1 or rstn=0. req_ready never asserts without matching req_valid.
- Transfer = req_valid[i] & req_ready[i] at a rising edge. On transfer, rr_ptr <= (granted index + 1) mod NREQ. Otherwise rr_ptr holds.
- Tag pipe: LAT stages of {vld, id}, all vld reset 0. Stage 0 loads {transfer, granted id} each edge. Each later stage loads from the previous one.
- Response stage: on each edge, resp_valid <= onehot(stage[LAT-1].id) if stage[LAT-1].vld, else 0. resp_y <= mul_y and resp_ovf <= mul_ovf when stage[LAT-1].vld. Otherwise resp_y and resp_ovf hold their value.
- Requesters have no back-pressure on responses. A result is presented for exactly one cycle and must be consumed then.
- busy = OR of all tag-pipe vld bits and any resp_valid bit.
- Operand values and results are passed through unmodified. The block does no FP arithmetic.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_y 0, resp_ovf 0, busy 0, ovf_sticky 0, rr_ptr 0, all tag vld 0.
- Transfer at edge k: mul_x1/mul_x2 show the operands in the cycle before edge k. resp_valid is high in the cycle after edge k+LAT. Accept-to-response latency is LAT+1 edges.
- Throughput: one issue per cycle, sustained back-to-back. Responses come out in issue order.
- hold asserted mid-stream: issue stops on the same cycle. Ops already issued still return on schedule. busy falls one cycle after the last resp_valid.
- Reset mid-operation: all in-flight tags are dropped and no resp_valid fires for them. Results the multiplier is still computing are ignored.
- req_valid dropped without a grant: allowed, no side effect. A requester's operands must stay stable while req_valid=1 && req_ready=0.

## Configuration
- FMUL_ARB_STICKY_OVF_EN defined: ovf_sticky[i] <= 1 on a response to i with resp_ovf=1. ovf_clr[i] clears it. If set and clear hit the same edge, set wins.
- Undefined: ovf_sticky is tied 0, ovf_clr is ignored, and no sticky flops are built.

## Structure
- Shared package fpu_pkg: FP_W=32 constant, fmul_tag_t struct {vld, id}, FMUL_LAT default constant.
- One sub-module: rr_arbiter (NREQ parameter; inputs req, en, ptr; outputs grant one-hot, grant_idx). The tag pipe and response register live in the top module.

## Test plan
- Single op: requester 0 sends x1=0x3FC00000 (1.5), x2=0x40000000 (2.0); multiplier model returns 0x40400000. Required: resp_valid=2'b01 and resp_y=0x40400000 exactly 3 edges after the transfer, busy drops afterward.
- Contention: both requesters hold req_valid for 4 cycles. Required grant order 0,1,0,1 and four responses with matching one-hot ids in the same order.
- Back-to-back: requester 1 issues 8 consecutive ops with x1 = i, x2 = 0x3F800000, model y = x1. Required: 8 consecutive resp_valid cycles to requester 1 with resp_y = 0..7.
- hold: hold=1 with requests pending. Required: req_ready=0, in-flight results still delivered, and issue resumes on the first cycle after hold falls, starting from the requester at rr_ptr.
- Reset mid-flight: rstn pulsed low one cycle after a transfer. Required: no resp_valid for that op, and all outputs at their reset values.
- Sticky ovf (macro defined): model drives mul_ovf=1 for requester 1. Required: ovf_sticky=2'b10. Then ovf_clr[1] on the same edge as a new ovf response: the flag stays 1.
